banked_reg_file: RTL and testbench
==================================

Name: banked_reg_file

Overview:
- Parametrised successor to the core's general register file: banked data RAM plus memory-mapped special function registers (SFRs).
- Adds indirect addressing (INDF/FSR), STATUS-driven bank select, a synchronised input port, and an output port with tristate control.
- Sits between the instruction decoder/ALU datapath and the I/O pins; the W register and ALU read and write it through one access port.

Parameters:
- DATA_W, 8, register width (minimum 8).
- ADDR_W, 7, direct address width per bank.
- NUM_BANKS, 2, number of RAM banks; legal values 1, 2, 4.
- SHARED_BASE, 'h70, first address of the common RAM window; the window runs to the top of the bank.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- addr  in  ADDR_W  direct register address.
- wr_en  in  1  write strobe for addr.
- wr_data  in  DATA_W  write data.
- rd_data  out  DATA_W  combinational read of addr in the current bank.
- status_we  in  1  ALU flag update strobe.
- status_flags  in  3  {DC,C,Z} from the ALU, placed into STATUS[2:0].
- status_out  out  DATA_W  current STATUS register.
- porta_in  in  DATA_W  asynchronous input pins.
- portb_out  out  DATA_W  PORTB output latch.
- portb_oe  out  DATA_W  per-bit output enable, equal to ~TRISB.
- busy  out  1  clear sequencer active (tied 0 when the optional feature is absent).

Behaviour:
- Bank select: effective bank = STATUS[6:5], truncated to clog2(NUM_BANKS) bits (0 bits when NUM_BANKS=1).
- Address map, decoded after bank select:
  - 0x00 INDF: access targets FSR, where FSR[ADDR_W-1:0] is the address and FSR[7] selects bank 0 or 1 (bank bit 1 taken from STATUS[6]). If the target is itself INDF, reads return 0 and writes are dropped.
  - 0x03 STATUS: shared by all banks.
  - 0x04 FSR: shared by all banks.
  - 0x05 bank0 PORTA: read only; returns the 2-flop synchronised porta_in (two-cycle latency); writes are ignored.
  - 0x06 bank0 PORTB latch; 0x06 bank1 TRISB.
  - SHARED_BASE to top: common RAM, the same word in every bank.
  - All other addresses: banked RAM, NUM_BANKS × 2^ADDR_W words.
- Read: purely combinational from addr, bank and FSR; no clock latency. A write becomes visible on rd_data the cycle after the edge.
- Write: occurs on the rising edge when wr_en=1 and busy=0.
- STATUS collision: if a wr_en write to STATUS and status_we land on the same edge, bits [7:3] take wr_data and bits [2:0] take status_flags. status_we alone updates only bits [2:0].
- Reset values: STATUS=0, FSR=0, PORTB=0, TRISB=all ones (portb_oe=0), synchroniser flops=0, busy=0.
- RAM contents are not reset unless the optional feature is enabled.
- Reset asserted mid-write aborts the write; SFRs return to their reset values immediately (asynchronous).
- Banks that do not exist (STATUS selects beyond NUM_BANKS) alias modulo NUM_BANKS.

Optional Feature:
- Macro: REGFILE_CLEAR_EN.
- Defined:
  - On reset release, a counter walks every RAM word (banked and shared), writing 0 at one word per cycle.
  - busy=1 from reset release until the cycle after the last word is cleared.
  - wr_en is ignored while busy; rd_data returns 0 for RAM addresses while busy.
  - SFRs are unaffected by the sequencer.
- Undefined: no sequencer; busy tied 0; RAM powers up undefined.

Test Plan:
- Reset, then write 0xA5 to 0x20 in bank0. Set STATUS[5]=1 and write 0x3C to 0x20. Read 0x20 in both banks -> 0xA5 and 0x3C respectively.
- Write 0x77 to 0x72 in bank0, switch to bank1 and read 0x72 -> 0x77 (shared window).
- Write FSR=0x85, then write 0x11 to INDF -> bank1 address 0x05 reads 0x11. Set FSR=0x00 and read INDF -> 0x00; a write to INDF in that state changes nothing.
- Drive porta_in=0x5A -> PORTA reads the old value for two edges, then 0x5A.
- Write TRISB=0xF0 and PORTB=0x0F -> portb_oe=0x0F, portb_out=0x0F.
- Same edge: STATUS write 0xE0 with status_we and flags=3'b101 -> status_out=0xE5.
- With REGFILE_CLEAR_EN defined, NUM_BANKS=2: busy stays high for 256 cycles after reset release (2 × 128 RAM words), a write attempted during busy is dropped, and every RAM address reads 0 afterwards.

Source files
------------

// File: rtl/banked_reg_file.sv
// rtl/banked_reg_file.sv - banked register file with SFRs, INDF/FSR indirection and PORTA/PORTB I/O
// Optional power-on RAM clear sequencer enabled by defining REGFILE_CLEAR_EN.
module banked_reg_file #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 7,
  parameter int NUM_BANKS   = 2,
  parameter int SHARED_BASE = 'h70
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_status_we,
  input  logic [2:0]        i_status_flags,
  output logic [DATA_W-1:0] o_status_out,
  input  logic [DATA_W-1:0] i_porta_in,
  output logic [DATA_W-1:0] o_portb_out,
  output logic [DATA_W-1:0] o_portb_oe,
  output logic              o_busy
);

  localparam int BANK_IW   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int RAM_DEPTH = 1 << ADDR_W;
  localparam int CNT_W     = ADDR_W + BANK_IW;
  localparam logic [1:0]        BANK_MASK = 2'(NUM_BANKS - 1);
  localparam logic [ADDR_W-1:0] A_INDF    = '0;
  localparam logic [ADDR_W-1:0] A_STATUS  = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_FSR     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_PORTA   = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_PORTB   = ADDR_W'(6);
  localparam logic [ADDR_W-1:0] A_SHARED  = ADDR_W'(SHARED_BASE);

  logic [DATA_W-1:0] r_ram [NUM_BANKS][RAM_DEPTH];
  logic [DATA_W-1:0] r_status;
  logic [DATA_W-1:0] r_fsr;
  logic [DATA_W-1:0] r_portb;
  logic [DATA_W-1:0] r_trisb;
  logic [DATA_W-1:0] r_sync1;
  logic [DATA_W-1:0] r_sync2;

  logic              w_clr_run;
  logic [BANK_IW-1:0] w_clr_bank;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_we;
  logic              w_is_indf;
  logic [ADDR_W-1:0] w_tgt_addr;
  logic [1:0]        w_bank_raw;
  logic [1:0]        w_bank;
  logic              w_shared;
  logic [BANK_IW-1:0] w_ram_bank;
  logic              w_sel_null;
  logic              w_sel_status;
  logic              w_sel_fsr;
  logic              w_sel_porta;
  logic              w_sel_portb;
  logic              w_sel_trisb;
  logic              w_sel_ram;
  logic [DATA_W-1:0] w_rd_data;

`ifdef REGFILE_CLEAR_EN
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BANKS * RAM_DEPTH - 1);

  logic [CNT_W-1:0] r_clr_cnt;
  logic             r_clr_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clr_cnt  <= '0;
      r_clr_done <= 1'b0;
    end else if (!r_clr_done) begin
      r_clr_cnt <= r_clr_cnt + 1'b1;
      if (r_clr_cnt == CNT_LAST) r_clr_done <= 1'b1;
    end
  end

  // r_clr_done is also 0 during reset, which blocks RAM writes at edges inside reset
  assign w_clr_run  = ~r_clr_done;
  assign w_clr_bank = r_clr_cnt[CNT_W-1:ADDR_W];
  assign w_clr_addr = r_clr_cnt[ADDR_W-1:0];
  assign o_busy     = i_rst_n & ~r_clr_done;
`else
  assign w_clr_run  = 1'b0;
  assign w_clr_bank = '0;
  assign w_clr_addr = '0;
  assign o_busy     = 1'b0;
`endif

  assign w_we = i_wr_en & ~w_clr_run;

  // INDF redirects through FSR; FSR[7] supplies bank bit 0, STATUS[6] bank bit 1
  assign w_is_indf  = (i_addr == A_INDF);
  assign w_tgt_addr = w_is_indf ? r_fsr[ADDR_W-1:0] : i_addr;
  assign w_bank_raw = w_is_indf ? {r_status[6], r_fsr[7]} : r_status[6:5];
  assign w_bank     = w_bank_raw & BANK_MASK;
  assign w_shared   = (w_tgt_addr >= A_SHARED);
  assign w_ram_bank = w_shared ? '0 : w_bank[BANK_IW-1:0];

  assign w_sel_null   = (w_tgt_addr == A_INDF);
  assign w_sel_status = (w_tgt_addr == A_STATUS);
  assign w_sel_fsr    = (w_tgt_addr == A_FSR);
  assign w_sel_porta  = (w_tgt_addr == A_PORTA) && (w_bank == 2'd0);
  assign w_sel_portb  = (w_tgt_addr == A_PORTB) && (w_bank == 2'd0);
  assign w_sel_trisb  = (w_tgt_addr == A_PORTB) && (w_bank == 2'd1);
  assign w_sel_ram    = ~(w_sel_null | w_sel_status | w_sel_fsr |
                          w_sel_porta | w_sel_portb | w_sel_trisb);

  always_ff @(posedge i_clk) begin
    if (w_clr_run) begin
      r_ram[w_clr_bank][w_clr_addr] <= '0;
    end else if (w_we && w_sel_ram) begin
      r_ram[w_ram_bank][w_tgt_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_status <= '0;
      r_fsr    <= '0;
      r_portb  <= '0;
      r_trisb  <= '1;
      r_sync1  <= '0;
      r_sync2  <= '0;
    end else begin
      r_sync1 <= i_porta_in;
      r_sync2 <= r_sync1;
      // ALU flags win bits [2:0] when they collide with a register write
      if (w_we && w_sel_status) begin
        r_status <= i_status_we ? {i_wr_data[DATA_W-1:3], i_status_flags} : i_wr_data;
      end else if (i_status_we) begin
        r_status[2:0] <= i_status_flags;
      end
      if (w_we && w_sel_fsr)   r_fsr   <= i_wr_data;
      if (w_we && w_sel_portb) r_portb <= i_wr_data;
      if (w_we && w_sel_trisb) r_trisb <= i_wr_data;
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (w_sel_status)               w_rd_data = r_status;
    else if (w_sel_fsr)             w_rd_data = r_fsr;
    else if (w_sel_porta)           w_rd_data = r_sync2;
    else if (w_sel_portb)           w_rd_data = r_portb;
    else if (w_sel_trisb)           w_rd_data = r_trisb;
    else if (w_sel_ram && !w_clr_run) w_rd_data = r_ram[w_ram_bank][w_tgt_addr];
  end

  assign o_rd_data    = w_rd_data;
  assign o_status_out = r_status;
  assign o_portb_out  = r_portb;
  assign o_portb_oe   = ~r_trisb;

endmodule

// File: tb/tb_banked_reg_file.sv
// tb/tb_banked_reg_file.sv - self-checking bench for banked_reg_file (default parameters)
module tb_banked_reg_file;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       status_we;
  logic [2:0] status_flags;
  logic [7:0] status_out;
  logic [7:0] porta_in;
  logic [7:0] portb_out;
  logic [7:0] portb_oe;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  banked_reg_file dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_rd_data(rd_data), .i_status_we(status_we), .i_status_flags(status_flags),
    .o_status_out(status_out), .i_porta_in(porta_in), .o_portb_out(portb_out),
    .o_portb_oe(portb_oe), .o_busy(busy)
  );

  typedef struct {
    logic       we;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       sw;
    logic [2:0] flags;
    logic [6:0] raddr;
    logic [7:0] exp_rd;
    logic [7:0] exp_st;
    logic [7:0] exp_pb;
    logic [7:0] exp_oe;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic we, input logic [6:0] a, input logic [7:0] d,
                              input logic sw, input logic [2:0] fl, input logic [6:0] ra,
                              input logic [7:0] erd, input logic [7:0] est,
                              input logic [7:0] epb, input logic [7:0] eoe);
    vec_t v;
    v.we = we; v.addr = a; v.wdata = d; v.sw = sw; v.flags = fl; v.raddr = ra;
    v.exp_rd = erd; v.exp_st = est; v.exp_pb = epb; v.exp_oe = eoe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    addr = a; wr_data = d; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; addr = 7'h04; wr_en = 1'b0; wr_data = '0;
    status_we = 1'b0; status_flags = '0; porta_in = '0;

    vecs[0]  = mk(1'b1, 7'h20, 8'hA5, 1'b0, 3'd0,     7'h20, 8'hA5, 8'h00, 8'h00, 8'h00);
    vecs[1]  = mk(1'b1, 7'h03, 8'h20, 1'b0, 3'd0,     7'h03, 8'h20, 8'h20, 8'h00, 8'h00);
    vecs[2]  = mk(1'b1, 7'h20, 8'h3C, 1'b0, 3'd0,     7'h20, 8'h3C, 8'h20, 8'h00, 8'h00);
    vecs[3]  = mk(1'b1, 7'h03, 8'h00, 1'b0, 3'd0,     7'h20, 8'hA5, 8'h00, 8'h00, 8'h00);
    vecs[4]  = mk(1'b1, 7'h72, 8'h77, 1'b0, 3'd0,     7'h72, 8'h77, 8'h00, 8'h00, 8'h00);
    vecs[5]  = mk(1'b1, 7'h03, 8'h20, 1'b0, 3'd0,     7'h72, 8'h77, 8'h20, 8'h00, 8'h00);
    vecs[6]  = mk(1'b0, 7'h20, 8'h00, 1'b0, 3'd0,     7'h20, 8'h3C, 8'h20, 8'h00, 8'h00);
    vecs[7]  = mk(1'b1, 7'h04, 8'h85, 1'b0, 3'd0,     7'h04, 8'h85, 8'h20, 8'h00, 8'h00);
    vecs[8]  = mk(1'b1, 7'h00, 8'h11, 1'b0, 3'd0,     7'h00, 8'h11, 8'h20, 8'h00, 8'h00);
    vecs[9]  = mk(1'b0, 7'h05, 8'h00, 1'b0, 3'd0,     7'h05, 8'h11, 8'h20, 8'h00, 8'h00);
    vecs[10] = mk(1'b1, 7'h03, 8'h00, 1'b0, 3'd0,     7'h05, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[11] = mk(1'b1, 7'h04, 8'h00, 1'b0, 3'd0,     7'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[12] = mk(1'b1, 7'h00, 8'h99, 1'b0, 3'd0,     7'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[13] = mk(1'b0, 7'h04, 8'h00, 1'b0, 3'd0,     7'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    vecs[14] = mk(1'b1, 7'h03, 8'hE0, 1'b1, 3'b101,   7'h03, 8'hE5, 8'hE5, 8'h00, 8'h00);
    vecs[15] = mk(1'b0, 7'h20, 8'h00, 1'b0, 3'd0,     7'h20, 8'h3C, 8'hE5, 8'h00, 8'h00);
    vecs[16] = mk(1'b0, 7'h03, 8'h00, 1'b1, 3'b010,   7'h03, 8'hE2, 8'hE2, 8'h00, 8'h00);
    vecs[17] = mk(1'b1, 7'h03, 8'h00, 1'b0, 3'd0,     7'h20, 8'hA5, 8'h00, 8'h00, 8'h00);
    vecs[18] = mk(1'b1, 7'h06, 8'h0F, 1'b0, 3'd0,     7'h06, 8'h0F, 8'h00, 8'h0F, 8'h00);
    vecs[19] = mk(1'b1, 7'h03, 8'h20, 1'b0, 3'd0,     7'h06, 8'hFF, 8'h20, 8'h0F, 8'h00);
    vecs[20] = mk(1'b1, 7'h06, 8'hF0, 1'b0, 3'd0,     7'h06, 8'hF0, 8'h20, 8'h0F, 8'h0F);
    vecs[21] = mk(1'b1, 7'h05, 8'h44, 1'b0, 3'd0,     7'h05, 8'h44, 8'h20, 8'h0F, 8'h0F);
    vecs[22] = mk(1'b1, 7'h03, 8'h00, 1'b0, 3'd0,     7'h05, 8'h00, 8'h00, 8'h0F, 8'h0F);
    vecs[23] = mk(1'b1, 7'h05, 8'h55, 1'b0, 3'd0,     7'h05, 8'h00, 8'h00, 8'h0F, 8'h0F);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_status", 32'(status_out), 32'h00);
    chk("reset_portb",  32'(portb_out),  32'h00);
    chk("reset_oe",     32'(portb_oe),   32'h00);
    chk("reset_busy",   32'(busy),       32'h0);
    chk("reset_fsr_rd", 32'(rd_data),    32'h00);
    rst_n = 1'b1;
    #1;

`ifdef REGFILE_CLEAR_EN
    begin
      int n;
      int errs;
      chk("busy_at_release", 32'(busy), 32'h1);
      addr = 7'h20; wr_data = 8'hEE; wr_en = 1'b1;
      n = 0;
      while (busy && n < 1000) begin
        @(posedge clk); #1;
        n++;
        if (n == 3) wr_en = 1'b0;
      end
      wr_en = 1'b0;
      chk("busy_cycles", 32'(n), 32'd256);
      for (int b = 0; b < 2; b++) begin
        wr(7'h03, (b == 0) ? 8'h00 : 8'h20);
        errs = 0;
        for (int a = 0; a < 128; a++) begin
          if (a == 0 || a == 3 || a == 4 || a == 6 || (a == 5 && b == 0)) continue;
          addr = 7'(a); #1;
          if (rd_data !== 8'h00) errs++;
        end
        chk($sformatf("clear_bank%0d_nonzero_words", b), 32'(errs), 32'd0);
      end
      wr(7'h03, 8'h00);
    end
`else
    chk("busy_idle", 32'(busy), 32'h0);
`endif

    for (int i = 0; i < 24; i++) begin
      addr = vecs[i].addr; wr_data = vecs[i].wdata; wr_en = vecs[i].we;
      status_we = vecs[i].sw; status_flags = vecs[i].flags;
      @(posedge clk); #1;
      wr_en = 1'b0; status_we = 1'b0; addr = vecs[i].raddr;
      #1;
      chk($sformatf("v%0d_rd", i),     32'(rd_data),    32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_status", i), 32'(status_out), 32'(vecs[i].exp_st));
      chk($sformatf("v%0d_portb", i),  32'(portb_out),  32'(vecs[i].exp_pb));
      chk($sformatf("v%0d_oe", i),     32'(portb_oe),   32'(vecs[i].exp_oe));
    end

    addr = 7'h05; porta_in = 8'h5A; #1;
    chk("porta_edge0", 32'(rd_data), 32'h00);
    @(posedge clk); #1;
    chk("porta_edge1", 32'(rd_data), 32'h00);
    @(posedge clk); #1;
    chk("porta_edge2", 32'(rd_data), 32'h5A);

    wr(7'h06, 8'hC3);
    chk("portb_pre_reset", 32'(portb_out), 32'hC3);
    wr(7'h04, 8'h12);
    addr = 7'h06; wr_data = 8'h3C; wr_en = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_portb",  32'(portb_out),  32'h00);
    chk("async_rst_oe",     32'(portb_oe),   32'h00);
    chk("async_rst_status", 32'(status_out), 32'h00);
    @(posedge clk); #1;
    chk("rst_edge_write_dropped", 32'(portb_out), 32'h00);
    wr_en = 1'b0; addr = 7'h04;
    rst_n = 1'b1; #1;
    chk("fsr_after_reset", 32'(rd_data), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
